// File: rtl/pc_pkg.sv
// Shared constants and types for the state-machine program counter and its return stack.
package pc_pkg;

  localparam int unsigned PC_RESET_VAL = 0;

  // Next-address source, listed from lowest to highest priority.
  typedef enum logic [1:0] {
    PC_CMD_SEQ,
    PC_CMD_JMP,
    PC_CMD_CALL,
    PC_CMD_RET
  } pc_cmd_e;

endpackage

// File: rtl/pc_ret_stack.sv
// Subroutine return-address LIFO with occupancy, sticky overflow/underflow flags and optional
// debug read port (PC_STACK_DBG_EN).
module pc_ret_stack #(
  parameter int unsigned AddrW = 5,
  parameter int unsigned Depth = 4,
  parameter int unsigned SpW   = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [AddrW-1:0] push_data_i,
  output logic [AddrW-1:0] top_o,
  output logic [SpW-1:0]   depth_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o,
  output logic             underflow_o
`ifdef PC_STACK_DBG_EN
  ,
  input  logic [SpW-1:0]   dbg_addr_i,
  output logic [AddrW-1:0] dbg_data_o
`endif
);

  logic [AddrW-1:0] mem_q [Depth];
  logic [SpW-1:0]   depth_q, depth_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             push_en;

  assign empty_o     = (depth_q == '0);
  assign full_o      = (depth_q == SpW'(Depth));
  assign depth_o     = depth_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

  // Pop wins over push; a push into a full stack is dropped.
  assign push_en = push_i & ~pop_i & ~clr_i & ~full_o;

  always_comb begin
    depth_d     = depth_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr_i) begin
      depth_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (pop_i) begin
      if (empty_o) underflow_d = 1'b1;
      else         depth_d     = depth_q - 1'b1;
    end else if (push_i) begin
      if (full_o) overflow_d = 1'b1;
      else        depth_d    = depth_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Entry contents need no reset: only slots below depth_q are ever read.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(Depth); i++) begin
      if (push_en && depth_q == SpW'(i)) mem_q[i] <= push_data_i;
    end
  end

  always_comb begin
    top_o = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      if (depth_q == SpW'(i + 1)) top_o = mem_q[i];
    end
  end

`ifdef PC_STACK_DBG_EN
  always_comb begin
    dbg_data_o = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      if (dbg_addr_i == SpW'(i) && SpW'(i) < depth_q) dbg_data_o = mem_q[i];
    end
  end
`else
`endif

endmodule

// File: rtl/pc_stack.sv
// State-machine program counter with wrap, jump and CALL/RET return stack.
// Define PC_STACK_DBG_EN to expose the dbg_addr/dbg_data stack read port.
module pc_stack
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SP_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              penable,
  input  logic              stalled,
  input  logic              restart,
  input  logic              jmp,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] din,
  input  logic [ADDR_W-1:0] pend,
  input  logic [ADDR_W-1:0] wrap_target,
  output logic [ADDR_W-1:0] dout,
  output logic [ADDR_W-1:0] index,
  output logic [SP_W-1:0]   depth,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              overflow,
  output logic              underflow
`ifdef PC_STACK_DBG_EN
  ,
  input  logic [SP_W-1:0]   dbg_addr,
  output logic [ADDR_W-1:0] dbg_data
`endif
);

  logic [ADDR_W-1:0] index_q, index_d;
  logic [ADDR_W-1:0] seq_addr, next_addr, stk_top;
  logic              adv;
  pc_cmd_e           cmd;

  assign adv      = penable & ~stalled & ~restart;
  assign seq_addr = (index_q == pend) ? wrap_target : index_q + 1'b1;

  always_comb begin
    if (ret)       cmd = PC_CMD_RET;
    else if (call) cmd = PC_CMD_CALL;
    else if (jmp)  cmd = PC_CMD_JMP;
    else           cmd = PC_CMD_SEQ;
  end

  always_comb begin
    next_addr = seq_addr;
    unique case (cmd)
      PC_CMD_RET:  next_addr = stack_empty ? seq_addr : stk_top;
      PC_CMD_CALL: next_addr = din;
      PC_CMD_JMP:  next_addr = din;
      PC_CMD_SEQ:  next_addr = seq_addr;
    endcase
  end

  always_comb begin
    index_d = index_q;
    if (restart)  index_d = ADDR_W'(PC_RESET_VAL);
    else if (adv) index_d = next_addr;
  end

  always_ff @(posedge clk) begin
    if (!reset) index_q <= ADDR_W'(PC_RESET_VAL);
    else        index_q <= index_d;
  end

  assign dout  = adv ? next_addr : index_q;
  assign index = index_q;

  // The return address is the wrap-adjusted sequential successor of the call site.
  pc_ret_stack #(
    .AddrW (ADDR_W),
    .Depth (DEPTH),
    .SpW   (SP_W)
  ) u_ret_stack (
    .clk_i       (clk),
    .rst_ni      (reset),
    .clr_i       (restart),
    .push_i      (adv && cmd == PC_CMD_CALL),
    .pop_i       (adv && cmd == PC_CMD_RET),
    .push_data_i (seq_addr),
    .top_o       (stk_top),
    .depth_o     (depth),
    .empty_o     (stack_empty),
    .full_o      (stack_full),
    .overflow_o  (overflow),
    .underflow_o (underflow)
`ifdef PC_STACK_DBG_EN
    ,
    .dbg_addr_i  (dbg_addr),
    .dbg_data_o  (dbg_data)
`endif
  );

endmodule

// File: tb/tb_pc_stack.sv
// Directed-vector bench for pc_stack (ADDR_W=5, DEPTH=4); covers the debug port when
// PC_STACK_DBG_EN is defined.
module tb_pc_stack;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SP_W   = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset, penable, stalled, restart, jmp, call, ret;
  logic [ADDR_W-1:0] din, pend, wrap_target, dout, index;
  logic [SP_W-1:0]   depth;
  logic              stack_empty, stack_full, overflow, underflow;
`ifdef PC_STACK_DBG_EN
  logic [SP_W-1:0]   dbg_addr;
  logic [ADDR_W-1:0] dbg_data;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  pc_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .penable     (penable),
    .stalled     (stalled),
    .restart     (restart),
    .jmp         (jmp),
    .call        (call),
    .ret         (ret),
    .din         (din),
    .pend        (pend),
    .wrap_target (wrap_target),
    .dout        (dout),
    .index       (index),
    .depth       (depth),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .overflow    (overflow),
    .underflow   (underflow)
`ifdef PC_STACK_DBG_EN
    ,
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs settle and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd_clear();
    jmp = 1'b0; call = 1'b0; ret = 1'b0;
  endtask

  task automatic check_state(input string tag, input int idx, input int dep);
    check({tag, ".index"}, 32'(index), 32'(idx));
    check({tag, ".depth"}, 32'(depth), 32'(dep));
  endtask

  int exp_seq[8] = '{1, 2, 3, 4, 5, 2, 3, 4};
  int exp_pop[4] = '{4, 3, 2, 3};

  initial begin
    reset = 1'b0; penable = 1'b0; stalled = 1'b0; restart = 1'b0;
    cmd_clear();
    din = '0; pend = 5'd5; wrap_target = 5'd2;
`ifdef PC_STACK_DBG_EN
    dbg_addr = '0;
`endif
    tick(); tick();
    check_state("rst", 0, 0);
    check("rst.empty", 32'(stack_empty), 1);
    check("rst.full", 32'(stack_full), 0);
    check("rst.ovf", 32'(overflow), 0);
    check("rst.unf", 32'(underflow), 0);

    // Sequential run with wrap 5 -> 2.
    reset = 1'b1; penable = 1'b1;
    #1;
    check("seq.dout0", 32'(dout), 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("seq.index%0d", i), 32'(index), 32'(exp_seq[i]));
    end
    reset = 1'b0;
    tick();
    check("seq.rst", 32'(index), 0);
    reset = 1'b1;
    pend = 5'd31;

    // Stalled call has no effect until the stall releases.
    stalled = 1'b1; call = 1'b1; din = 5'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_state($sformatf("stall%0d", i), 0, 0);
      check($sformatf("stall%0d.dout", i), 32'(dout), 0);
    end
    stalled = 1'b0;
    #1;
    check("stall.rel.dout", 32'(dout), 9);
    tick();
    check_state("stall.rel", 9, 1);
    cmd_clear();
    penable = 1'b0;
    tick();
    check_state("pen0", 9, 1);
    check("pen0.dout", 32'(dout), 9);
    penable = 1'b1;

    // Restart empties the stack; then call/ret around the call site.
    restart = 1'b1;
    tick();
    check_state("restart1", 0, 0);
    restart = 1'b0;
    tick(); tick(); tick(); tick();
    check("cr.at4", 32'(index), 4);
    call = 1'b1; din = 5'd20;
    tick();
    check_state("cr.call", 20, 1);
    call = 1'b0; ret = 1'b1;
    #1;
    check("cr.ret.dout", 32'(dout), 5);
    tick();
    check_state("cr.ret", 5, 0);
    ret = 1'b0;
    pend = 5'd5; wrap_target = 5'd2;
    call = 1'b1; din = 5'd10;
    tick();
    check_state("cr.wcall", 10, 1);
    call = 1'b0; ret = 1'b1;
    tick();
    check_state("cr.wret", 2, 0);
    ret = 1'b0;
    pend = 5'd31;

    // Overflow: fifth call dropped from the stack but still jumps.
    call = 1'b1;
    din = 5'd1; tick();
    din = 5'd2; tick();
    din = 5'd3; tick();
    din = 5'd4; tick();
    check("ovf.full4", 32'(stack_full), 1);
    check("ovf.pre", 32'(overflow), 0);
    din = 5'd6; tick();
    check_state("ovf", 6, 4);
    check("ovf.flag", 32'(overflow), 1);
    call = 1'b0; ret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_state($sformatf("pop%0d", i), exp_pop[i], 3 - i);
    end
    ret = 1'b0;
    check("pop.empty", 32'(stack_empty), 1);
    check("pop.ovf.sticky", 32'(overflow), 1);

    // Underflow and command priority.
    restart = 1'b1;
    tick();
    check("rs.ovf", 32'(overflow), 0);
    restart = 1'b0;
    jmp = 1'b1; din = 5'd7;
    tick();
    check("jmp7", 32'(index), 7);
    jmp = 1'b0; ret = 1'b1;
    #1;
    check("unf.dout", 32'(dout), 8);
    tick();
    check_state("unf", 8, 0);
    check("unf.flag", 32'(underflow), 1);
    ret = 1'b0; call = 1'b1; din = 5'd15;
    tick();
    check_state("pr.call", 15, 1);
    ret = 1'b1; din = 5'd20;
    tick();
    check_state("pr.callret", 9, 0);
    check("pr.unf.sticky", 32'(underflow), 1);
    ret = 1'b0; jmp = 1'b1; din = 5'd12;
    tick();
    check_state("pr.calljmp", 12, 1);
    cmd_clear();
    restart = 1'b1; penable = 1'b0;
    #1;
    check("rs2.dout", 32'(dout), 12);
    tick();
    check_state("rs2", 0, 0);
    check("rs2.unf", 32'(underflow), 0);
    check("rs2.ovf", 32'(overflow), 0);
    restart = 1'b0; penable = 1'b1;

`ifdef PC_STACK_DBG_EN
    jmp = 1'b1; din = 5'd2; tick();
    jmp = 1'b0; call = 1'b1; din = 5'd10; tick();
    call = 1'b0; jmp = 1'b1; din = 5'd6; tick();
    jmp = 1'b0; call = 1'b1; din = 5'd20; tick();
    call = 1'b0; penable = 1'b0;
    dbg_addr = 'd0; #1; check("dbg0", 32'(dbg_data), 3);
    dbg_addr = 'd1; #1; check("dbg1", 32'(dbg_data), 7);
    dbg_addr = 'd2; #1; check("dbg2", 32'(dbg_data), 0);
    check("dbg.depth", 32'(depth), 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised successor of the PIO state-machine program counter.
- Adds configurable address width, a subroutine return stack (CALL/RET) of configurable depth, a synchronous restart, and stack status/error flags.
- Sits in each state machine between the instruction decoder (jmp/call/ret/target) and instruction memory (dout = fetch address).

Parameters:
- ADDR_W, 5, width of PC, jump target and wrap registers (program memory depth = 2**ADDR_W).
- DEPTH, 4, return-stack entries; legal range 1..16.
- SP_W, $clog2(DEPTH+1), stack pointer / occupancy width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- penable  in  1  state-machine clock-divider enable; no PC or stack change when low.
- stalled  in  1  current instruction stalled; no PC or stack change when high.
- restart  in  1  synchronous SM restart: PC <- 0, stack emptied, sticky flags cleared; ignores penable/stalled.
- jmp  in  1  taken jump to din.
- call  in  1  jump to din and push return address.
- ret  in  1  pop return address into PC.
- din  in  ADDR_W  jump/call target.
- pend  in  ADDR_W  wrap top address.
- wrap_target  in  ADDR_W  wrap bottom address.
- dout  out  ADDR_W  next fetch address (combinational look-ahead).
- index  out  ADDR_W  current PC register.
- depth  out  SP_W  stack occupancy.
- stack_empty  out  1  depth == 0.
- stack_full  out  1  depth == DEPTH.
- overflow  out  1  sticky: call attempted while full.
- underflow  out  1  sticky: ret attempted while empty.

Behaviour:
- Reset (reset==0 at clk edge): index=0, depth=0, overflow=0, underflow=0. Stack contents are don't-care. Reset overrides restart and all commands.
- restart==1 (reset high): same effect as reset, same cycle.
- adv = penable && !stalled && !restart. When adv==0, index, depth and the flags hold, and dout = index.
- Sequential next: seq = (index == pend) ? wrap_target : index+1. The +1 wraps modulo 2**ADDR_W.
- Command priority when adv==1: ret > call > jmp > sequential.
  - ret, depth>0: next = top entry; depth decrements.
  - ret, depth==0: next = seq; underflow<=1.
  - call, depth<DEPTH: next = din; push seq (the wrap-adjusted return address); depth increments.
  - call, depth==DEPTH: next = din; push dropped, stack unchanged; overflow<=1.
  - jmp: next = din.
  - none: next = seq.
- dout = next when adv==1, else index. Combinational, zero latency. index <= next at the clock edge (1-cycle latency).
- Any command asserted together with ret is ignored.
- call with din == return address is legal.
- Flags are cleared only by reset or restart.
- stack_empty and stack_full are derived from the depth register. They are not registered separately.

Optional Feature:
- PC_STACK_DBG_EN defined: adds ports dbg_addr (in, SP_W) and dbg_data (out, ADDR_W).
  - dbg_data is the combinational read of stack entry dbg_addr (0 = bottom).
  - Returns 0 if dbg_addr >= depth.
  - Has no side effects.
- Undefined: the ports are absent, and the stack storage may be inferred as a LIFO without random read.

Decomposition:
- Package pc_pkg:
  - PC_RESET_VAL (0).
  - Command priority enum PC_CMD_{SEQ,JMP,CALL,RET}, used for the internal next-select.
- Sub-module pc_ret_stack (LIFO) owns:
  - storage, depth, push/pop, full/empty;
  - overflow/underflow detection;
  - debug read when PC_STACK_DBG_EN.
- pc_stack keeps next-address selection and the index register.

Test Plan:
- Reset/wrap (ADDR_W=5), wrap_target=2, pend=5, free-running 8 enabled cycles -> index 0,1,2,3,4,5,2,3,4. reset=0 mid-run -> index=0 next edge.
- Stall/enable: stalled=1 with call=1, din=9 for 3 cycles -> index and depth unchanged, dout=index. Release stall -> index=9, depth=1.
- Call/ret: at index=4 (pend=31), call din=20 -> index=20, depth=1. Then ret -> index=5, depth=0. At index=pend=5, wrap_target=2, call din=10 -> return address 2 pushed.
- Overflow (DEPTH=4): five calls din=1,2,3,4,6 -> depth=4, index=6, overflow=1; top entry still return of 4th call. Four rets drain in LIFO order.
- Underflow and priority: ret at depth 0 from index 7 -> index=8, underflow=1. call+ret same cycle at depth 1 -> pop only, depth 0. restart -> index=0, flags 0.
- PC_STACK_DBG_EN build: after calls pushing 3,7 -> dbg_addr 0 gives 3, dbg_addr 1 gives 7, dbg_addr 2 gives 0.
